trace_step_loader: RTL and testbench

- Upstream feeder for the tiny86 step checker.
- Deserializes a narrow, framed trace stream (16-bit beats, LSB-first) into full 560-bit trace steps.
- Presents each step on a valid/ready output with a running step index; the tiny86 `step` input is driven from `out_step`.
- Detects framing errors and holds a sticky error flag; one assembly buffer plus one output register give zero-bubble streaming.

---
 rtl/trace_step_loader_if.sv | 29 ++
 rtl/trace_step_loader.sv | 116 +++++++++++
 tb/tb_trace_step_loader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_step_loader_if.sv
// Beat-in / step-out handshake bundle for trace_step_loader.
// slave is the loader side, master is the feeder/consumer side.
interface trace_step_loader_if #(
  parameter int unsigned STEP_W = 560,
  parameter int unsigned WORD_W = 16,
  parameter int unsigned IDX_W  = 32
) ();

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_sop;
  logic              out_valid;
  logic              out_ready;
  logic [STEP_W-1:0] out_step;
  logic [IDX_W-1:0]  out_index;
  logic              frame_err;

  modport master (
    output in_valid, in_data, in_sop, out_ready,
    input  in_ready, out_valid, out_step, out_index, frame_err
  );

  modport slave (
    input  in_valid, in_data, in_sop, out_ready,
    output in_ready, out_valid, out_step, out_index, frame_err
  );

endinterface

// File: rtl/trace_step_loader.sv
// Deserializes LSB-first framed 16-bit beats into full trace steps, with one assembly
// buffer plus one output register so steps stream without bubbles.
module trace_step_loader #(
  parameter int unsigned STEP_W = 560,
  parameter int unsigned WORD_W = 16,
  parameter int unsigned IDX_W  = 32
) (
  input logic                 clk,
  input logic                 rst,
  trace_step_loader_if.slave  bus
);

  localparam int unsigned BEATS = STEP_W / WORD_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(BEATS - 1);

  if ((STEP_W % WORD_W) != 0) begin : g_bad_width
    $fatal(1, "trace_step_loader: STEP_W must be a multiple of WORD_W");
  end

  typedef enum logic [1:0] {StIdle, StFill, StFull} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [STEP_W-1:0] asm_q;
  logic              out_valid_q;
  logic [STEP_W-1:0] out_step_q;
  logic [IDX_W-1:0]  out_index_q;
  logic              frame_err_q;

  logic              in_ready;
  logic              accept;
  logic              take;
  logic              out_free;
  logic [CNT_W-1:0]  pos;
  logic [STEP_W-1:0] merged;

  assign in_ready = (state_q != StFull);
  assign accept   = bus.in_valid & in_ready;
  assign take     = out_valid_q & bus.out_ready;
  // Output register can accept a load if empty or being drained this cycle.
  assign out_free = ~out_valid_q | bus.out_ready;

  // Beat slot: a start-of-packet or a beat in IDLE always lands at position 0.
  always_comb begin
    pos    = (state_q == StIdle || bus.in_sop) ? '0 : cnt_q;
    merged = asm_q;
    merged[pos*WORD_W +: WORD_W] = bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      asm_q       <= '0;
      out_valid_q <= 1'b0;
      out_step_q  <= '0;
      out_index_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      if (take) begin
        out_valid_q <= 1'b0;
        out_index_q <= out_index_q + IDX_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (bus.in_sop) begin
              asm_q   <= merged;
              cnt_q   <= CNT_W'(1);
              state_q <= StFill;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        StFill: begin
          if (accept) begin
            asm_q <= merged;
            if (bus.in_sop) begin
              // Restart: the partial step is dropped and this beat becomes beat 0.
              frame_err_q <= 1'b1;
              cnt_q       <= CNT_W'(1);
            end else if (cnt_q == LastCnt) begin
              cnt_q <= '0;
              if (out_free) begin
                out_step_q  <= merged;
                out_valid_q <= 1'b1;
                state_q     <= StIdle;
              end else begin
                state_q <= StFull;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        StFull: begin
          if (out_free) begin
            out_step_q  <= asm_q;
            out_valid_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_step  = out_step_q;
  assign bus.out_index = out_index_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_trace_step_loader.sv
// Bench for trace_step_loader: beat-level framing model plus step scoreboard,
// a scenario table, hand-written corner sequences and a randomized run.
module tb_trace_step_loader;

  localparam int STEP_W = 560;
  localparam int WORD_W = 16;
  localparam int BEATS  = 35;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trace_step_loader_if #(.STEP_W(STEP_W), .WORD_W(WORD_W), .IDX_W(32)) bus ();

  trace_step_loader #(.STEP_W(STEP_W), .WORD_W(WORD_W), .IDX_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [STEP_W-1:0] exp_q[$];
  logic [WORD_W-1:0] part[$];
  bit                m_err;
  int unsigned       take_cnt;

  bit                acc, last_rdy, last_ov;
  logic [STEP_W-1:0] last_step;
  logic [31:0]       last_idx;
  bit                prev_hold;
  logic [STEP_W-1:0] hold_step;
  logic [31:0]       hold_idx;
  int                cyc_no, takes_seen, ov_cycles, rdy_low;
  int                take_cyc[$];

  typedef struct {
    int stray;
    int abort_at;
    int nsteps;
    bit rr;
    int exp_takes;
    bit exp_err;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [STEP_W-1:0] act,
                     input logic [STEP_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Framing rules applied to the accepted beat stream.
  task automatic model_beat(input bit s, input logic [WORD_W-1:0] d);
    logic [STEP_W-1:0] st;
    if (s) begin
      if (part.size() != 0) m_err = 1'b1;
      part.delete();
      part.push_back(d);
    end else if (part.size() == 0) begin
      m_err = 1'b1;
    end else begin
      part.push_back(d);
    end
    if (part.size() == BEATS) begin
      for (int k = 0; k < BEATS; k++) st[k*WORD_W +: WORD_W] = part[k];
      exp_q.push_back(st);
      part.delete();
    end
  endtask

  task automatic cyc(input bit v, input bit s, input logic [WORD_W-1:0] d, input bit r);
    bit tk;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sop = s;
    bus.in_data = d;
    bus.out_ready = r;
    #1;
    last_rdy  = bus.in_ready;
    last_ov   = bus.out_valid;
    last_step = bus.out_step;
    last_idx  = bus.out_index;
    acc = v && last_rdy;
    tk  = last_ov && r;
    chk("frame_err", bus.frame_err, m_err);
    if (prev_hold) begin
      chk("hold_valid", last_ov, 1);
      chk("hold_step", last_step, hold_step);
      chk("hold_index", last_idx, hold_idx);
    end
    prev_hold = last_ov && !r;
    hold_step = last_step;
    hold_idx  = last_idx;
    if (v && !last_rdy) rdy_low++;
    if (last_ov) ov_cycles++;
    if (tk) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_step: got index %0d, no step expected", last_idx);
      end else begin
        chk("out_step", last_step, exp_q.pop_front());
      end
      chk("out_index", last_idx, take_cnt);
      take_cnt++;
      takes_seen++;
      take_cyc.push_back(cyc_no);
    end
    if (acc) model_beat(s, d);
    cyc_no++;
    @(posedge clk);
  endtask

  task automatic send_beat(input bit s, input logic [WORD_W-1:0] d, input bit r, input bit rr);
    int tries = 0;
    do begin
      cyc(1'b1, s, d, rr ? 1'($urandom_range(0, 1)) : r);
      tries++;
    end while (!acc && tries < 300);
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL beat_accept_timeout: beat %0h not accepted, required within 300 cycles", d);
    end
  endtask

  task automatic send_step(input logic [WORD_W-1:0] base, input bit r, input bit rr,
                           input int abort_at);
    for (int k = 0; k < abort_at; k++) send_beat(k == 0, 16'hA000 + 16'(k), r, rr);
    for (int k = 0; k < BEATS; k++) send_beat(k == 0, base + 16'(k), r, rr);
  endtask

  task automatic drain(input int n);
    repeat (n) cyc(1'b0, 1'b0, '0, 1'b1);
  endtask

  // Asynchronous mid-cycle reset; outputs must clear before any clock edge.
  task automatic do_reset();
    #3;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_index", bus.out_index, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    chk("rst_out_step", bus.out_step, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    part.delete();
    m_err = 1'b0;
    take_cnt = 0;
    prev_hold = 1'b0;
    takes_seen = 0;
    ov_cycles = 0;
    rdy_low = 0;
    take_cyc.delete();
  endtask

  initial begin
    int spacing;
    int pos;
    bit v, s, r;
    bus.in_valid = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    vecs = '{
      '{stray: 0, abort_at: 0,  nsteps: 1, rr: 1'b0, exp_takes: 1, exp_err: 1'b0},
      '{stray: 1, abort_at: 0,  nsteps: 1, rr: 1'b0, exp_takes: 1, exp_err: 1'b1},
      '{stray: 0, abort_at: 20, nsteps: 1, rr: 1'b0, exp_takes: 1, exp_err: 1'b1},
      '{stray: 2, abort_at: 0,  nsteps: 3, rr: 1'b1, exp_takes: 3, exp_err: 1'b1},
      '{stray: 0, abort_at: 0,  nsteps: 4, rr: 1'b1, exp_takes: 4, exp_err: 1'b0}
    };
    @(posedge clk);
    do_reset();

    // Single step, beat k carries k.
    send_step(16'h0000, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("lat_valid", last_ov, 1);
    chk("lat_beat0", last_step[15:0], 0);
    chk("lat_beat34", last_step[559:544], 34);
    chk("lat_index", last_idx, 0);
    drain(3);
    chk("single_takes", takes_seen, 1);
    chk("single_ov_cycles", ov_cycles, 1);

    // Two back-to-back steps.
    do_reset();
    send_step(16'h1000, 1'b1, 1'b0, 0);
    send_step(16'h2000, 1'b1, 1'b0, 0);
    drain(3);
    spacing = (take_cyc.size() >= 2) ? take_cyc[1] - take_cyc[0] : -1;
    chk("b2b_ready_low", rdy_low, 0);
    chk("b2b_takes", takes_seen, 2);
    chk("b2b_ov_cycles", ov_cycles, 2);
    chk("b2b_spacing", spacing, 35);

    // Backpressure: step 0 held, step 1 parked in assembly.
    do_reset();
    send_step(16'h3000, 1'b0, 1'b0, 0);
    send_step(16'h4000, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b1, 16'h5000, 1'b0);
    chk("bp_ready_low", last_rdy, 0);
    chk("bp_valid_held", last_ov, 1);
    chk("bp_index0", last_idx, 0);
    cyc(1'b1, 1'b1, 16'h5000, 1'b1);
    chk("bp_ready_still_low", last_rdy, 0);
    cyc(1'b1, 1'b1, 16'h5000, 1'b1);
    chk("bp_ready_back", last_rdy, 1);
    chk("bp_valid_step1", last_ov, 1);
    chk("bp_index1", last_idx, 1);
    for (int k = 1; k < BEATS; k++) send_beat(1'b0, 16'h5000 + 16'(k), 1'b1, 1'b0);
    drain(3);
    chk("bp_takes", takes_seen, 3);

    // Scenario table.
    foreach (vecs[i]) begin
      do_reset();
      for (int j = 0; j < vecs[i].stray; j++) cyc(1'b1, 1'b0, 16'hBAD0 + 16'(j), 1'b1);
      for (int n = 0; n < vecs[i].nsteps; n++)
        send_step(16'(n * 64), 1'b1, vecs[i].rr, (n == 0) ? vecs[i].abort_at : 0);
      drain(80);
      chk($sformatf("tbl%0d_takes", i), takes_seen, vecs[i].exp_takes);
      chk($sformatf("tbl%0d_err", i), bus.frame_err, vecs[i].exp_err);
      chk($sformatf("tbl%0d_drained", i), exp_q.size(), 0);
    end

    // Reset in the middle of a step.
    do_reset();
    for (int k = 0; k < 17; k++) send_beat(k == 0, 16'hC000 + 16'(k), 1'b1, 1'b0);
    do_reset();
    send_step(16'h6000, 1'b1, 1'b0, 0);
    drain(3);
    chk("midrst_takes", takes_seen, 1);

    // Reset while FULL with out_valid held.
    do_reset();
    send_step(16'h7000, 1'b0, 1'b0, 0);
    send_step(16'h7100, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("full_ready_low", last_rdy, 0);
    chk("full_valid", last_ov, 1);
    do_reset();
    send_step(16'h7200, 1'b1, 1'b0, 0);
    drain(3);
    chk("fullrst_takes", takes_seen, 1);

    // Randomized traffic with occasional framing faults.
    do_reset();
    pos = 0;
    for (int c = 0; c < 4000; c++) begin
      v = ($urandom_range(0, 3) != 0);
      s = (pos == 0);
      if ($urandom_range(0, 63) == 0) s = !s;
      r = ($urandom_range(0, 2) != 0);
      cyc(v, s, 16'($urandom), r);
      if (acc) pos = s ? 1 : ((pos == 0) ? 0 : (pos + 1) % BEATS);
    end
    drain(100);
    chk("rand_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
